// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, runs the instruction SRAM handshake and
// hands {ce, pc} plus the fetched word to ID, honouring MIPS branch delay slots.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFBF_FFFC,
    parameter int          STALL_W  = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic [32:0]        br_bus,
    output logic               inst_sram_req,
    output logic [31:0]        inst_sram_addr,
    input  logic               inst_sram_addr_ok,
    input  logic               inst_sram_data_ok,
    input  logic [31:0]        inst_sram_rdata,
    output logic [32:0]        if_to_id_bus,
    output logic [31:0]        if_inst,
    output logic               stallreq_if
);

    localparam logic STOP = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic        ce_r;
    logic [31:0] inst_r;
    logic [31:0] fetch_pc_r;
    logic        pend_br_r;
    logic [31:0] pend_addr_r;
    logic [31:0] hold_inst_r;
    logic        req_r;

    logic        br_e_s;
    logic [31:0] br_addr_s;
    logic        tgt_en_s;
    logic [31:0] tgt_s;
    logic        deliver_s;
    logic [31:0] deliver_inst_s;
    logic        stallreq_s;

    assign br_e_s    = br_bus[32];
    assign br_addr_s = br_bus[31:0];
    assign tgt_en_s  = pend_br_r | br_e_s;
    assign tgt_s     = pend_br_r ? pend_addr_r : br_addr_s;

    assign if_to_id_bus   = {ce_r, pc_r};
    assign if_inst        = inst_r;
    assign inst_sram_addr = fetch_pc_r;
    assign inst_sram_req  = req_r;
    assign stallreq_if    = stallreq_s;

    // Delivery decision, source of the delivered word, and IF stall request.
    always_comb begin
        deliver_s      = 1'b0;
        deliver_inst_s = inst_sram_rdata;
        stallreq_s     = 1'b0;
        case (state_r)
            S_REQ: begin
                stallreq_s = 1'b1;
            end
            S_WAIT: begin
                stallreq_s = ~inst_sram_data_ok;
                deliver_s  = inst_sram_data_ok & (stall[0] != STOP);
            end
            S_HOLD: begin
                deliver_s      = (stall[0] != STOP);
                deliver_inst_s = hold_inst_r;
            end
            default: begin
                deliver_s  = 1'b0;
                stallreq_s = 1'b0;
            end
        endcase
    end

    // PC/IF registers, pending-branch capture and the fetch handshake FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= S_IDLE;
            pc_r        <= RESET_PC;
            ce_r        <= 1'b0;
            inst_r      <= 32'h0000_0000;
            fetch_pc_r  <= 32'h0000_0000;
            pend_br_r   <= 1'b0;
            pend_addr_r <= 32'h0000_0000;
            hold_inst_r <= 32'h0000_0000;
            req_r       <= 1'b0;
        end else begin
            // A branch seen while delivering means this word is its delay slot.
            if (deliver_s) begin
                pc_r       <= fetch_pc_r;
                ce_r       <= 1'b1;
                inst_r     <= deliver_inst_s;
                fetch_pc_r <= tgt_en_s ? tgt_s : (fetch_pc_r + 32'd4);
                pend_br_r  <= 1'b0;
            end else if (br_e_s && !pend_br_r) begin
                pend_br_r   <= 1'b1;
                pend_addr_r <= br_addr_s;
            end

            case (state_r)
                S_IDLE: begin
                    fetch_pc_r <= pc_r + 32'd4;
                    state_r    <= S_REQ;
                    req_r      <= 1'b1;
                end
                S_REQ: begin
                    if (inst_sram_addr_ok) begin
                        state_r <= S_WAIT;
                        req_r   <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (inst_sram_data_ok) begin
                        if (deliver_s) begin
                            state_r <= S_REQ;
                            req_r   <= 1'b1;
                        end else begin
                            hold_inst_r <= inst_sram_rdata;
                            state_r     <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (deliver_s) begin
                        state_r <= S_REQ;
                        req_r   <= 1'b1;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    req_r   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a small SRAM responder with programmable data latency
// plus hand-computed expectations for delivery order, branches, stalls and reset.
module tb_if_fetch;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic [32:0] br_bus;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic [32:0] if_to_id_bus;
    logic [31:0] if_inst;
    logic        stallreq_if;

    int checks_total;
    int checks_passed;

    int          lat;
    logic        stray;
    logic        busy;
    int          cnt;
    logic [31:0] lat_addr;

    if_fetch #(.RESET_PC(32'hBFBF_FFFC), .STALL_W(6)) dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .br_bus            (br_bus),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .if_to_id_bus      (if_to_id_bus),
        .if_inst           (if_inst),
        .stallreq_if       (stallreq_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'hBFC0_0000) return 32'h3408_0001;
        return {a[15:0], 16'h1234};
    endfunction

    // SRAM responder: accepts any request at once, returns data 'lat' cycles later.
    initial begin
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = 32'h0000_0000;
        busy     = 1'b0;
        cnt      = 0;
        lat_addr = 32'h0000_0000;
        forever begin
            @(negedge clk);
            inst_sram_addr_ok = 1'b0;
            inst_sram_data_ok = 1'b0;
            if (!rst) begin
                busy              = 1'b0;
                inst_sram_data_ok = stray;
                inst_sram_rdata   = 32'hDEAD_BEEF;
            end else if (busy) begin
                if (cnt == 0) begin
                    inst_sram_data_ok = 1'b1;
                    inst_sram_rdata   = mem_word(lat_addr);
                    busy              = 1'b0;
                end else begin
                    cnt = cnt - 1;
                end
            end else if (inst_sram_req) begin
                inst_sram_addr_ok = 1'b1;
                lat_addr          = inst_sram_addr;
                cnt               = lat - 1;
                busy              = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_total = checks_total + 1;
        if (got === exp) begin
            checks_passed = checks_passed + 1;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Runs until the next delivery; also counts cycles with stallreq_if high on the way.
    task automatic fetch_one(input string tag, input int exp_stalls,
                             input logic [31:0] exp_pc, input logic [31:0] exp_inst);
        logic [32:0] old_bus;
        int n;
        int cyc;
        old_bus = if_to_id_bus;
        n   = 0;
        cyc = 0;
        while (if_to_id_bus === old_bus && cyc < 40) begin
            if (stallreq_if) n = n + 1;
            step();
            cyc = cyc + 1;
        end
        chk({tag, "_pc"},     {31'd0, if_to_id_bus}, {31'd0, 1'b1, exp_pc});
        chk({tag, "_inst"},   {32'd0, if_inst},      {32'd0, exp_inst});
        chk({tag, "_stalls"}, 64'(n),                64'(exp_stalls));
    endtask

    task automatic wait_data_ok(input string tag);
        int cyc;
        cyc = 0;
        while (!inst_sram_data_ok && cyc < 40) begin
            step();
            cyc = cyc + 1;
        end
        chk({tag, "_tmo"}, {63'd0, inst_sram_data_ok}, 64'd1);
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        rst    = 1'b0;
        stall  = 6'd0;
        br_bus = 33'd0;
        lat    = 1;
        stray  = 1'b0;

        step();
        step();
        chk("rst_bus",  {31'd0, if_to_id_bus},  {31'd0, 1'b0, 32'hBFBF_FFFC});
        chk("rst_inst", {32'd0, if_inst},       64'd0);
        chk("rst_req",  {63'd0, inst_sram_req}, 64'd0);
        chk("rst_stl",  {63'd0, stallreq_if},   64'd0);
        chk("rst_addr", {32'd0, inst_sram_addr}, 64'd0);

        // Basic first fetch, one-cycle data latency
        rst = 1'b1;
        fetch_one("t1", 1, 32'hBFC0_0000, 32'h3408_0001);
        chk("t1_addr", {32'd0, inst_sram_addr}, {32'd0, 32'hBFC0_0004});
        chk("t1_req",  {63'd0, inst_sram_req},  64'd1);

        // Straight line; 0004 was already accepted with latency 1
        lat = 3;
        fetch_one("t2a", 1, 32'hBFC0_0004, 32'h0004_1234);
        fetch_one("t2b", 3, 32'hBFC0_0008, 32'h0008_1234);
        chk("t2_addr", {32'd0, inst_sram_addr}, {32'd0, 32'hBFC0_000C});

        // Branch in the delivery cycle: delivered word is the delay slot
        lat = 1;
        wait_data_ok("t3");
        br_bus = {1'b1, 32'hBFC0_0100};
        step();
        br_bus = 33'd0;
        chk("t3_pc",   {31'd0, if_to_id_bus},   {31'd0, 1'b1, 32'hBFC0_000C});
        chk("t3_inst", {32'd0, if_inst},        {32'd0, 32'h000C_1234});
        chk("t3_addr", {32'd0, inst_sram_addr}, {32'd0, 32'hBFC0_0100});
        chk("t3_req",  {63'd0, inst_sram_req},  64'd1);
        lat = 3;
        fetch_one("t3b", 1, 32'hBFC0_0100, 32'h0100_1234);
        chk("t3b_addr", {32'd0, inst_sram_addr}, {32'd0, 32'hBFC0_0104});

        // Branch pulse while waiting: latched, second branch must not overwrite it
        step();
        chk("t4_wait_stl", {63'd0, stallreq_if}, 64'd1);
        br_bus = {1'b1, 32'hBFC0_0200};
        step();
        br_bus = {1'b1, 32'hBFC0_0300};
        step();
        br_bus = 33'd0;
        fetch_one("t4", 0, 32'hBFC0_0104, 32'h0104_1234);
        chk("t4_addr", {32'd0, inst_sram_addr}, {32'd0, 32'hBFC0_0200});
        lat = 1;
        fetch_one("t4b", 3, 32'hBFC0_0200, 32'h0200_1234);
        chk("t4b_addr", {32'd0, inst_sram_addr}, {32'd0, 32'hBFC0_0204});

        // Stall across data_ok: word buffered, released later
        stall = 6'b000001;
        step();
        chk("t5_dok",  {63'd0, inst_sram_data_ok}, 64'd1);
        chk("t5_stl",  {63'd0, stallreq_if},       64'd0);
        step();
        chk("t5_hstl", {63'd0, stallreq_if},       64'd0);
        chk("t5_hpc",  {31'd0, if_to_id_bus},      {31'd0, 1'b1, 32'hBFC0_0200});
        chk("t5_hins", {32'd0, if_inst},           {32'd0, 32'h0200_1234});
        chk("t5_hreq", {63'd0, inst_sram_req},     64'd0);
        step();
        step();
        stall = 6'd0;
        step();
        chk("t5_pc",   {31'd0, if_to_id_bus},   {31'd0, 1'b1, 32'hBFC0_0204});
        chk("t5_inst", {32'd0, if_inst},        {32'd0, 32'h0204_1234});
        chk("t5_req",  {63'd0, inst_sram_req},  64'd1);
        chk("t5_addr", {32'd0, inst_sram_addr}, {32'd0, 32'hBFC0_0208});

        // Reset while waiting, with stray data_ok during reset and the idle cycle
        step();
        stray = 1'b1;
        rst   = 1'b0;
        #1;
        chk("t6_bus",  {31'd0, if_to_id_bus},  {31'd0, 1'b0, 32'hBFBF_FFFC});
        chk("t6_inst", {32'd0, if_inst},       64'd0);
        chk("t6_req",  {63'd0, inst_sram_req}, 64'd0);
        step();
        step();
        chk("t6_dok",  {63'd0, inst_sram_data_ok}, 64'd1);
        chk("t6_stl",  {63'd0, stallreq_if},       64'd0);
        rst   = 1'b1;
        stray = 1'b0;
        fetch_one("t6", 1, 32'hBFC0_0000, 32'h3408_0001);
        chk("t6_addr", {32'd0, inst_sram_addr}, {32'd0, 32'hBFC0_0004});

        // Branch to the top of the address space: next fetch wraps to zero
        wait_data_ok("t7");
        br_bus = {1'b1, 32'hFFFF_FFFC};
        step();
        br_bus = 33'd0;
        chk("t7_pc", {31'd0, if_to_id_bus}, {31'd0, 1'b1, 32'hBFC0_0004});
        fetch_one("t7b", 1, 32'hFFFF_FFFC, 32'hFFFC_1234);
        chk("t7_addr", {32'd0, inst_sram_addr}, 64'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage (IF plus the IF/ID boundary), sitting directly upstream of ID.
- Holds the PC and drives the instruction SRAM through a req/addr_ok/data_ok handshake.
- Applies branch redirects from ID's br_bus, keeping MIPS delay-slot semantics.
- Presents {ce, pc} and the fetched instruction to ID, and raises a stall request while a fetch is outstanding.

Parameters:
RESET_PC, 32'hBFBF_FFFC, PC value held at reset; the first fetch address is RESET_PC+4 (32'hBFC0_0000).
STALL_W, 6, width of stall bus (`StallBus).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-low (0 = reset).
stall  in  STALL_W  pipeline stall vector; stall[0]==`Stop (1) freezes PC/IF.
br_bus  in  33  {br_e, br_addr[31:0]} from ID, combinational, valid the same cycle.
inst_sram_req  out  1  fetch request.
inst_sram_addr  out  32  fetch address.
inst_sram_addr_ok  in  1  address accepted this cycle.
inst_sram_data_ok  in  1  rdata valid this cycle.
inst_sram_rdata  in  32  instruction data.
if_to_id_bus  out  33  {ce, pc[31:0]} to ID.
if_inst  out  32  instruction matching if_to_id_bus.pc.
stallreq_if  out  1  IF not ready; feeds the stall controller.

Behaviour:
- Reset values (async on rst==0):
  - pc_reg = RESET_PC, ce = 0, if_inst = 0.
  - state = S_IDLE, pend_br = 0, pend_addr = 0, fetch_pc = 0.
  - inst_sram_req = 0, stallreq_if = 0.
- if_to_id_bus = {ce, pc_reg}.
- inst_sram_addr = fetch_pc.
- inst_sram_req = 1 only in S_REQ.
- Target select: tgt_en = pend_br | br_e; tgt = pend_br ? pend_addr : br_addr.
- FSM:
  - S_IDLE: first cycle after reset release. fetch_pc <= pc_reg+4. Go to S_REQ. data_ok in S_IDLE is ignored.
  - S_REQ: hold req and fetch_pc until addr_ok. On addr_ok go to S_WAIT. fetch_pc must not change while req=1.
  - S_WAIT: wait for data_ok. On data_ok:
    - If stall[0]==`NoStop ("deliver"): pc_reg <= fetch_pc, ce <= 1, if_inst <= rdata. fetch_pc <= tgt_en ? tgt : fetch_pc+4. Clear pend_br. Go to S_REQ.
    - Else: buffer rdata into hold_inst and go to S_HOLD.
  - S_HOLD: on stall[0]==`NoStop, deliver from hold_inst (same updates as above) and go to S_REQ.
- One delivery per instruction; at most one SRAM transaction outstanding; addr_ok and data_ok of the same transaction never share a cycle.
- Delay slot: a branch seen in ID in the delivery cycle means the instruction being delivered is its delay slot, so the next fetch is the target.
- Pending branch: if br_e=1 in a cycle with no delivery, latch pend_br <= 1 and pend_addr <= br_addr. A later br_e while pend_br=1 does not overwrite it.
- stallreq_if = 1 in S_REQ and S_WAIT when data_ok=0. It is 0 in S_IDLE, S_HOLD, and in S_WAIT when data_ok=1.
- When stall[0]==`Stop and no delivery occurs: pc_reg, ce and if_inst hold.
- pc_reg+4 and fetch_pc+4 wrap modulo 2^32 (32'hFFFF_FFFC+4 = 0).
- Reset mid-transaction: state returns to S_IDLE. Any data_ok or addr_ok arriving before S_REQ is re-entered is ignored.
- Instruction latency: 0 wait states gives one instruction per 2 cycles (REQ, WAIT). The registered if_inst/pc are seen by ID the cycle after delivery.

Test Plan:
1. Reset then release; SRAM gives addr_ok immediately and data_ok 1 cycle later, rdata=32'h3408_0001 -> first req addr 32'hBFC0_0000; after delivery if_to_id_bus={1,32'hBFC0_0000}, if_inst=32'h3408_0001; next req addr 32'hBFC0_0004.
2. Straight-line run with 3-cycle data_ok latency -> pc sequence BFC00000, BFC00004, BFC00008; stallreq_if high for exactly the wait cycles of each fetch.
3. br_bus={1,32'hBFC0_0100} asserted in the delivery cycle of 32'hBFC0_0004 -> 32'hBFC0_0004 (delay slot) delivered; next req addr 32'hBFC0_0100.
4. br_e pulsed for 1 cycle while in S_WAIT (no delivery), br_addr=32'hBFC0_0200 -> pend_br set; next fetch after delivery is 32'hBFC0_0200; pend_br cleared.
5. stall[0]=1 for 4 cycles across data_ok -> state S_HOLD, pc/if_inst unchanged, stallreq_if=0; on release deliver the buffered word and issue the next req the following cycle.
6. rst=0 asserted while in S_WAIT, stray data_ok during reset and in the S_IDLE cycle -> outputs at reset values, stray data ignored; fetch restarts at 32'hBFC0_0000.
